// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: read-modify-write for byte/half/word stores, extended loads.
// Optional memory-mapped LED register enabled by defining DATA_MEM_CTRL_LED_MMIO_EN.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  input  logic [3:0]  sign_mask_i,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  output logic [7:0]  led_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        store;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  led_q, led_d;
  logic        mem_we;
  logic [31:0] rword, merged;
  logic        is_led;
  logic        req_vld;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_vld = memwrite_i | memread_i;
  assign idx     = req_q.addr[AW+1:2];

`ifdef DATA_MEM_CTRL_LED_MMIO_EN
  assign is_led = (req_q.addr[31:2] == LED_ADDR[31:2]);
`else
  assign is_led = 1'b0;
`endif

  // Upper address bits only matter for the LED decode; RAM index wraps.
  logic unused_ok;
  assign unused_ok = ^{req_q.addr[31:AW+2], LED_ADDR};

  assign rword = is_led ? {24'b0, led_q} : mem[idx];

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [3:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (m[2:0])
      3'b001:  load_ext = m[3] ? {{24{b[7]}}, b} : {24'b0, b};
      3'b011:  load_ext = m[3] ? {{16{h[15]}}, h} : {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] a, input logic [2:0] m);
    store_merge = w;
    case (m)
      3'b001: case (a)
        2'd0:    store_merge[7:0]   = d[7:0];
        2'd1:    store_merge[15:8]  = d[7:0];
        2'd2:    store_merge[23:16] = d[7:0];
        default: store_merge[31:24] = d[7:0];
      endcase
      3'b011: if (a[1]) store_merge[31:16] = d[15:0];
              else      store_merge[15:0]  = d[15:0];
      default: store_merge = d;
    endcase
  endfunction

  assign merged = store_merge(word_q, req_q.wdata, req_q.addr[1:0], req_q.mask[2:0]);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rd_data_d = rd_data_q;
    word_d    = word_q;
    led_d     = led_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: if (req_vld) begin
        // A simultaneous read+write request is handled as a store.
        req_d   = '{addr: addr_i, wdata: wr_data_i, mask: sign_mask_i, store: memwrite_i};
        state_d = READ;
      end
      READ: begin
        word_d = rword;
        if (req_q.store) state_d = WRITE;
        else begin
          rd_data_d = load_ext(rword, req_q.addr[1:0], req_q.mask);
          state_d   = DONE;
        end
      end
      WRITE: begin
`ifdef DATA_MEM_CTRL_LED_MMIO_EN
        if (is_led) led_d = merged[7:0];
        else        mem_we = 1'b1;
`else
        mem_we = 1'b1;
`endif
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rd_data_q <= '0;
      word_q    <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rd_data_q <= rd_data_d;
      word_q    <= word_d;
      led_q     <= led_d;
    end
  end

  // RAM has no reset; an async reset drops the FSM out of WRITE before the edge.
  always_ff @(posedge clk_i) begin
    if (mem_we && rstn_i) mem[idx] <= merged;
  end

  assign stall_o   = rstn_i & (((state_q == IDLE) & req_vld) |
                               (state_q == READ) | (state_q == WRITE));
  assign rd_data_o = rd_data_q;
  assign led_o     = led_q;
endmodule
